// File: rtl/amux_sel_ctrl_if.sv
// Request/response bundle between the trim/config logic (master) and the analog-mux
// select sequencer (slave).
interface amux_sel_ctrl_if #(
  parameter int SEL_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [SEL_W-1:0] req_sel;
  logic             req_en;
  logic [SEL_W-1:0] sel_a;
  logic             sel_en;
  logic             busy;
  logic             done;
  logic             scan_start;
  logic             scan_stop;
  logic             scan_tick;

  modport master (
    output req_valid, req_sel, req_en, scan_start, scan_stop,
    input  req_ready, sel_a, sel_en, busy, done, scan_tick
  );

  modport slave (
    input  req_valid, req_sel, req_en, scan_start, scan_stop,
    output req_ready, sel_a, sel_en, busy, done, scan_tick
  );
endinterface

// File: rtl/amux_sel_ctrl.sv
// Break-before-make sequencer for the 5:32 analog-mux decoder select/enable.
// Optional auto-scan mode is built only when AMUX_SCAN_EN is defined.
module amux_sel_ctrl #(
  parameter int SEL_W      = 5,
  parameter int BBM_CYC    = 4,
  parameter int SETTLE_CYC = 16,
  parameter int SCAN_DWELL = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  amux_sel_ctrl_if.slave bus
);

  localparam int CNT_MAX_A = (BBM_CYC > SETTLE_CYC) ? BBM_CYC : SETTLE_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > SCAN_DWELL) ? CNT_MAX_A : SCAN_DWELL;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BREAK, S_SWITCH, S_MAKE, S_DONE, S_DWELL, S_HOLD
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [SEL_W-1:0] code_reg, code_next;
  logic             en_reg, en_next;
  logic             fast_reg, fast_next;
  logic [SEL_W-1:0] sel_a_reg, sel_a_next;
  logic             sel_en_reg, sel_en_next;
  logic             done_reg, done_next;
  logic             ready_reg, ready_next;
  logic             busy_reg, busy_next;

  logic             scan_req;
  logic             scan_active;
  logic             stop_hit;
  logic             accept;
  logic             scan_launch;

  assign accept      = (state_reg == S_IDLE) && ready_reg && bus.req_valid;
  assign scan_launch = (state_reg == S_IDLE) && ready_reg && !bus.req_valid && scan_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      code_reg   <= '0;
      en_reg     <= 1'b0;
      fast_reg   <= 1'b0;
      sel_a_reg  <= '0;
      sel_en_reg <= 1'b0;
      done_reg   <= 1'b0;
      ready_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      code_reg   <= code_next;
      en_reg     <= en_next;
      fast_reg   <= fast_next;
      sel_a_reg  <= sel_a_next;
      sel_en_reg <= sel_en_next;
      done_reg   <= done_next;
      ready_reg  <= ready_next;
      busy_reg   <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    code_next  = code_reg;
    en_next    = en_reg;
    fast_next  = fast_reg;
    unique case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (accept) begin
          code_next  = bus.req_sel;
          en_next    = bus.req_en;
          // Already enabled on the requested code: nothing to switch.
          fast_next  = (bus.req_sel == sel_a_reg) && sel_en_reg && bus.req_en;
          state_next = fast_next ? S_SWITCH : S_BREAK;
        end else if (scan_launch) begin
          code_next  = '0;
          en_next    = 1'b1;
          fast_next  = 1'b0;
          state_next = S_BREAK;
        end
      end
      S_BREAK:  if (cnt_reg == CNT_W'(BBM_CYC - 1)) state_next = S_SWITCH;
      S_SWITCH: state_next = (en_reg && !fast_reg) ? S_MAKE : S_DONE;
      S_MAKE: begin
        if (cnt_reg == CNT_W'(SETTLE_CYC - 1))
          state_next = scan_active ? S_DWELL : S_DONE;
      end
      S_DWELL: begin
        if (cnt_reg == CNT_W'(SCAN_DWELL - 1)) begin
          if (stop_hit) begin
            state_next = S_HOLD;
          end else begin
            code_next  = code_reg + 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_HOLD:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (state_next != state_reg) cnt_next = '0;
  end

  // Output registers are loaded on state transitions, so sel_a and sel_en never move together.
  always_comb begin
    sel_a_next  = sel_a_reg;
    sel_en_next = sel_en_reg;
    done_next   = 1'b0;
    busy_next   = (state_next != S_IDLE);
    ready_next  = (state_next == S_IDLE);
    if (state_next != state_reg) begin
      unique case (state_next)
        S_BREAK:  sel_en_next = 1'b0;
        S_SWITCH: if (state_reg == S_BREAK) sel_a_next = code_reg;
        S_MAKE:   sel_en_next = 1'b1;
        S_DONE:   done_next = 1'b1;
        default:  ;
      endcase
    end
  end

  assign bus.sel_a     = sel_a_reg;
  assign bus.sel_en    = sel_en_reg;
  assign bus.done      = done_reg;
  assign bus.req_ready = ready_reg;
  assign bus.busy      = busy_reg;

`ifdef AMUX_SCAN_EN
  logic scan_reg, scan_next;
  logic stop_reg, stop_next;
  logic tick_reg, tick_next;

  assign scan_req    = bus.scan_start;
  assign scan_active = scan_reg;
  assign stop_hit    = stop_reg | bus.scan_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_reg <= 1'b0;
      stop_reg <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      scan_reg <= scan_next;
      stop_reg <= stop_next;
      tick_reg <= tick_next;
    end
  end

  // A stop request is remembered until the next end-of-dwell consumes it.
  always_comb begin
    scan_next = scan_reg;
    stop_next = stop_reg | bus.scan_stop;
    tick_next = (state_reg == S_DWELL) && (state_next != S_DWELL);
    if (state_next == S_IDLE) scan_next = 1'b0;
    if (scan_launch) begin
      scan_next = 1'b1;
      stop_next = bus.scan_stop;
    end
    if ((state_reg == S_DWELL) && (state_next == S_HOLD)) stop_next = 1'b0;
  end

  assign bus.scan_tick = tick_reg;
`else
  logic scan_unused;

  assign scan_req      = 1'b0;
  assign scan_active   = 1'b0;
  assign stop_hit      = 1'b0;
  assign scan_unused   = bus.scan_start | bus.scan_stop;
  assign bus.scan_tick = 1'b0;
`endif

endmodule

// File: tb/tb_amux_sel_ctrl.sv
// Randomised self-checking bench for amux_sel_ctrl against a timeline model of the
// break-before-make sequence (scan checks selected by AMUX_SCAN_EN).
module tb_amux_sel_ctrl;

  localparam int BBM    = 4;
  localparam int SETTLE = 16;
  localparam int DWELL  = 8;
  localparam int P      = BBM + 1 + SETTLE + DWELL;

  typedef struct packed {
    logic [4:0] sel;
    logic       en;
    logic       done;
    logic       ready;
    logic       busy;
    logic       tick;
  } smp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  smp_t obs[64];
  logic [4:0] cur_sel;
  logic       cur_en;

  amux_sel_ctrl_if #(.SEL_W(5)) bus ();

  amux_sel_ctrl #(
    .SEL_W(5), .BBM_CYC(BBM), .SETTLE_CYC(SETTLE), .SCAN_DWELL(DWELL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic smp_t sample();
    return '{bus.sel_a, bus.sel_en, bus.done, bus.req_ready, bus.busy, bus.scan_tick};
  endfunction

  function automatic string fmt(smp_t v);
    return $sformatf("sel=%0d en=%0b done=%0b rdy=%0b busy=%0b tick=%0b",
                     v.sel, v.en, v.done, v.ready, v.busy, v.tick);
  endfunction

  // Edge index (after accept edge T0) at which done is expected.
  function automatic int last_k(logic [4:0] cs, logic ce, logic [4:0] s, logic e);
    if (s == cs && ce && e) return 1;
    return e ? (BBM + 1 + SETTLE) : (BBM + 1);
  endfunction

  function automatic smp_t expect_req(int k, logic [4:0] cs, logic ce, logic [4:0] s, logic e);
    smp_t m;
    int   dk = last_k(cs, ce, s, e);
    bit   fast = (s == cs) && ce && e;
    m.done  = (k == dk);
    m.ready = (k > dk);
    m.busy  = (k <= dk);
    m.tick  = 1'b0;
    if (fast) begin
      m.sel = cs;
      m.en  = 1'b1;
    end else begin
      m.sel = (k >= BBM) ? s : cs;
      m.en  = e && (k >= BBM + 1);
    end
    return m;
  endfunction

  // Drives one request once the block is ready and records n samples, sample k taken 1ns after edge T0+k.
  task automatic run_req(input logic [4:0] s, input logic e, input bit noise, input int n);
    int w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (!bus.req_ready) begin
      n_fail++;
      $display("FAIL ready_wait got req_ready=0 want 1 within 200 cycles");
    end
    bus.req_valid = 1'b1;
    bus.req_sel   = s;
    bus.req_en    = e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      obs[k] = sample();
      if (noise) begin
        bus.req_valid = 1'b1;
        bus.req_sel   = 5'($urandom);
        bus.req_en    = 1'($urandom);
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    smp_t o;
    bus.req_valid = 0; bus.req_sel = 0; bus.req_en = 0;
    bus.scan_start = 0; bus.scan_stop = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    o = sample();
    n_checks++;
    if (o !== smp_t'('0)) begin
      n_fail++;
      $display("FAIL reset_outputs got %s want all zero", fmt(o));
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_before_edge got %b want 0", bus.req_ready);
    end
    @(posedge clk);
    #1;
    o = sample();
    n_checks++;
    if (o !== smp_t'{5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_ready_after_edge got %s want rdy=1 others 0", fmt(o));
    end
    cur_sel = 5'd0;
    cur_en  = 1'b0;
  endtask

  task automatic test_full_switch();
    smp_t e_s;
    int   dk = last_k(cur_sel, cur_en, 5'd17, 1'b1);
    run_req(5'd17, 1'b1, 1'b0, dk + 2);
    for (int k = 0; k < dk + 2; k++) begin
      e_s = expect_req(k, cur_sel, cur_en, 5'd17, 1'b1);
      n_checks++;
      if (obs[k] !== e_s) begin
        n_fail++;
        $display("FAIL full_switch k=%0d got %s want %s", k, fmt(obs[k]), fmt(e_s));
      end
    end
    n_checks++;
    if (!(obs[3].sel == 5'd0 && obs[4].sel == 5'd17 && obs[4].en == 1'b0 && obs[5].en == 1'b1
          && obs[20].done == 1'b0 && obs[21].done == 1'b1 && obs[22].ready == 1'b1)) begin
      n_fail++;
      $display("FAIL full_switch_timing got sel@4=%0d en@5=%b done@21=%b rdy@22=%b want 17 1 1 1",
               obs[4].sel, obs[5].en, obs[21].done, obs[22].ready);
    end
    cur_sel = 5'd17;
    cur_en  = 1'b1;
  endtask

  task automatic test_fast_path();
    smp_t e_s;
    run_req(5'd17, 1'b1, 1'b0, 3);
    for (int k = 0; k < 3; k++) begin
      e_s = expect_req(k, cur_sel, cur_en, 5'd17, 1'b1);
      n_checks++;
      if (obs[k] !== e_s || obs[k].en !== 1'b1) begin
        n_fail++;
        $display("FAIL fast_path k=%0d got %s want %s", k, fmt(obs[k]), fmt(e_s));
      end
    end
  endtask

  task automatic test_disabled_switch();
    smp_t e_s;
    int   dk = last_k(cur_sel, cur_en, 5'd3, 1'b0);
    run_req(5'd3, 1'b0, 1'b1, dk + 2);
    for (int k = 0; k < dk + 2; k++) begin
      e_s = expect_req(k, cur_sel, cur_en, 5'd3, 1'b0);
      n_checks++;
      if (obs[k] !== e_s) begin
        n_fail++;
        $display("FAIL disabled_switch k=%0d got %s want %s", k, fmt(obs[k]), fmt(e_s));
      end
    end
    cur_sel = 5'd3;
    cur_en  = 1'b0;
  endtask

  task automatic test_mid_reset();
    int   abort_k[2] = '{4, 9};
    smp_t o;
    smp_t e_s;
    foreach (abort_k[i]) begin
      run_req(5'd17, 1'b1, 1'b0, abort_k[i] + 1);
      e_s = expect_req(abort_k[i], cur_sel, cur_en, 5'd17, 1'b1);
      n_checks++;
      if (obs[abort_k[i]] !== e_s) begin
        n_fail++;
        $display("FAIL abort_pre k=%0d got %s want %s", abort_k[i], fmt(obs[abort_k[i]]), fmt(e_s));
      end
      rst_n = 1'b0;
      #1;
      o = sample();
      n_checks++;
      if (o !== smp_t'('0)) begin
        n_fail++;
        $display("FAIL abort_reset k=%0d got %s want all zero", abort_k[i], fmt(o));
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      o = sample();
      n_checks++;
      if (o !== smp_t'{5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL abort_release k=%0d got %s want rdy=1 others 0", abort_k[i], fmt(o));
      end
      cur_sel = 5'd0;
      cur_en  = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [4:0] s;
    logic       e;
    smp_t       e_s;
    int         dk;
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = cur_sel;
        e = 1'b1;
      end else begin
        s = 5'($urandom);
        e = ($urandom_range(0, 3) != 0);
      end
      dk = last_k(cur_sel, cur_en, s, e);
      run_req(s, e, 1'b1, dk + 2);
      for (int k = 0; k < dk + 2; k++) begin
        e_s = expect_req(k, cur_sel, cur_en, s, e);
        n_checks++;
        if (obs[k] !== e_s) begin
          n_fail++;
          $display("FAIL random t=%0d k=%0d got %s want %s", t, k, fmt(obs[k]), fmt(e_s));
        end
      end
      if (!((s == cur_sel) && cur_en && e)) begin
        cur_sel = s;
        cur_en  = e;
      end
    end
  endtask

`ifdef AMUX_SCAN_EN
  // Round r applies code r mod 32; the tick ending round r lands on edge (r+1)*P.
  task automatic test_scan();
    smp_t       o;
    smp_t       e_s;
    int         r, ofs;
    int         w = 0;
    logic [4:0] code, prev;
    @(negedge clk);
    while (!bus.req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    bus.req_valid  = 1'b0;
    bus.scan_start = 1'b1;
    for (int k = 0; k <= 35 * P + 3; k++) begin
      @(posedge clk);
      #1;
      o = sample();
      bus.scan_start = 1'b0;
      bus.scan_stop  = (k == 34 * P + 10);
      if (k >= 35 * P) begin
        e_s = '{5'd2, 1'b1, (k == 35 * P + 1), (k >= 35 * P + 2), (k < 35 * P + 2), (k == 35 * P)};
      end else begin
        r    = k / P;
        ofs  = k % P;
        code = 5'(r % 32);
        prev = (r == 0) ? cur_sel : 5'((r - 1) % 32);
        e_s  = '{(ofs >= BBM) ? code : prev, (ofs >= BBM + 1), 1'b0, 1'b0, 1'b1, (k > 0 && ofs == 0)};
      end
      n_checks++;
      if (o !== e_s) begin
        n_fail++;
        $display("FAIL scan k=%0d got %s want %s", k, fmt(o), fmt(e_s));
      end
    end
    bus.scan_stop = 1'b0;
    cur_sel = 5'd2;
    cur_en  = 1'b1;
  endtask
`else
  task automatic test_scan_ignored();
    smp_t o;
    smp_t e_s;
    e_s = '{cur_sel, cur_en, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.scan_start = 1'b1;
      bus.scan_stop  = k[0];
      @(posedge clk);
      #1;
      o = sample();
      n_checks++;
      if (o !== e_s) begin
        n_fail++;
        $display("FAIL scan_ignored k=%0d got %s want %s", k, fmt(o), fmt(e_s));
      end
    end
    bus.scan_start = 1'b0;
    bus.scan_stop  = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_switch();
    test_fast_path();
    test_disabled_switch();
    test_mid_reset();
    test_random();
`ifdef AMUX_SCAN_EN
    test_scan();
`else
    test_scan_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
